// File: rtl/bicubic_pkg.sv
// Shared widths and the round/shift/limit helper for the
// bicubic multiplier pipeline.
package bicubic_pkg;

    localparam int A_W_DEF   = 10;
    localparam int B_W_DEF   = 18;
    localparam int LANES_DEF = 4;

    // Products are rounded and limited in a fixed wide signed format.
    localparam int RW = 65;

    function automatic int pw(input int a_w, input int b_w);
        return a_w + b_w;
    endfunction

    function automatic logic [RW:0] round_shift_sat(
        input logic signed [RW-1:0] p,
        input logic                 sgn,
        input int                   shift,
        input int                   out_w,
        input logic                 sat
    );
        logic signed [RW-1:0] r;
        logic signed [RW-1:0] hi;
        logic signed [RW-1:0] lo;
        logic signed [RW-1:0] v;
        logic                 ovf;
        r = p;
        if (shift > 0)
            r = (p + (65'sd1 <<< (shift - 1))) >>> shift;
        if (sgn) begin
            hi = (65'sd1 <<< (out_w - 1)) - 65'sd1;
            lo = -(65'sd1 <<< (out_w - 1));
        end else begin
            hi = (65'sd1 <<< out_w) - 65'sd1;
            lo = '0;
        end
        ovf = (r > hi) || (r < lo);
        v = r;
        if (sat && (r > hi))
            v = hi;
        else if (sat && (r < lo))
            v = lo;
        return {ovf, v};
    endfunction

endpackage

// File: rtl/bicubic_mul_lane.sv
// One multiplier lane: product register, delay line, round/limit
// output register. Validity is tracked by the parent.
module bicubic_mul_lane
    import bicubic_pkg::*;
#(
    parameter int A_W     = A_W_DEF,
    parameter int B_W     = B_W_DEF,
    parameter int LATENCY = 4,
    parameter int SIGNED  = 0,
    parameter int SHIFT   = 0,
    parameter int OUT_W   = 28,
    parameter int SAT     = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             adv,
    input  logic             flush,
    input  logic [A_W-1:0]   a,
    input  logic [B_W-1:0]   b,
    output logic [OUT_W-1:0] p,
    output logic             ovf
);

    localparam int PW = pw(A_W, B_W);
    localparam int ND = LATENCY - 1;

    logic [PW-1:0] ax;
    logic [PW-1:0] bx;
    logic [PW-1:0] prod;
    logic [PW-1:0] pr [ND];
    logic [RW-1:0] pe;
    logic [RW:0]   res;
    logic          en;
    logic          unused_res;

    assign en = adv && !flush;

    // Low PW bits of the extended product are exact in both modes.
    always_comb begin
        ax   = {{B_W{(SIGNED != 0) && a[A_W-1]}}, a};
        bx   = {{A_W{(SIGNED != 0) && b[B_W-1]}}, b};
        prod = ax * bx;
    end

    always_comb begin
        pe  = {{(RW-PW){(SIGNED != 0) && pr[ND-1][PW-1]}}, pr[ND-1]};
        res = round_shift_sat(pe, SIGNED != 0, SHIFT, OUT_W, SAT != 0);
    end

    assign unused_res = ^res[RW-1:OUT_W];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < ND; i++)
                pr[i] <= '0;
            p   <= '0;
            ovf <= 1'b0;
        end else if (en) begin
            pr[0] <= prod;
            for (int i = 1; i < ND; i++)
                pr[i] <= pr[i-1];
            p   <= res[OUT_W-1:0];
            ovf <= res[RW];
        end
    end

endmodule

// File: rtl/bicubic_mul_pipe.sv
// Multi-lane pipelined multiplier with round/limit and a
// valid/ready tag shift register shared by all lanes.
module bicubic_mul_pipe
    import bicubic_pkg::*;
#(
    parameter int A_W     = A_W_DEF,
    parameter int B_W     = B_W_DEF,
    parameter int LANES   = LANES_DEF,
    parameter int LATENCY = 4,
    parameter int SIGNED  = 0,
    parameter int SHIFT   = 0,
    parameter int OUT_W   = 28,
    parameter int SAT     = 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   flush,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [LANES*A_W-1:0]   in_a,
    input  logic [LANES*B_W-1:0]   in_b,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [LANES*OUT_W-1:0] out_p,
    output logic [LANES-1:0]       out_ovf
);

    logic [LATENCY-1:0] vld;
    logic               adv;

    assign out_valid = vld[LATENCY-1];
    assign adv       = !out_valid || out_ready;
    assign in_ready  = adv;

    // Flush wins over accept and advance; data regs are left alone.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            vld <= '0;
        else if (flush)
            vld <= '0;
        else if (adv)
            vld <= {vld[LATENCY-2:0], in_valid};
    end

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        bicubic_mul_lane #(
            .A_W     (A_W),
            .B_W     (B_W),
            .LATENCY (LATENCY),
            .SIGNED  (SIGNED),
            .SHIFT   (SHIFT),
            .OUT_W   (OUT_W),
            .SAT     (SAT)
        ) u_lane (
            .clk   (clk),
            .rst_n (rst_n),
            .adv   (adv),
            .flush (flush),
            .a     (in_a[i*A_W +: A_W]),
            .b     (in_b[i*B_W +: B_W]),
            .p     (out_p[i*OUT_W +: OUT_W]),
            .ovf   (out_ovf[i])
        );
    end

endmodule

// File: tb/tb_bicubic_mul_pipe.sv
// Self-checking bench: five configurations share one stimulus
// stream and are checked against an arithmetic reference model.
module tb_bicubic_mul_pipe;

    localparam int NI = 5;
    localparam int SG [NI] = '{0, 1, 0, 1, 1};
    localparam int SH [NI] = '{0, 0, 8, 0, 0};
    localparam int OW [NI] = '{28, 28, 28, 16, 16};
    localparam int ST [NI] = '{1, 1, 1, 1, 0};

    typedef struct {
        logic [39:0] a;
        logic [71:0] b;
    } beat_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        out_ready;
    logic [39:0] in_a;
    logic [71:0] in_b;

    logic         ir  [NI];
    logic         ovd [NI];
    logic [111:0] op  [NI];
    logic [3:0]   ov  [NI];
    logic [111:0] op0, op1, op2;
    logic [63:0]  op3, op4;

    beat_t q [$];
    int    n_assert = 0;
    int    n_fail   = 0;
    int    n_out    = 0;

    always #5 clk = ~clk;

    always_comb begin
        op[0] = op0;
        op[1] = op1;
        op[2] = op2;
        op[3] = {48'b0, op3};
        op[4] = {48'b0, op4};
    end

    bicubic_mul_pipe #(.SIGNED(0), .SHIFT(0), .OUT_W(28), .SAT(1)) d0 (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid),
        .in_ready(ir[0]), .in_a(in_a), .in_b(in_b), .out_valid(ovd[0]),
        .out_ready(out_ready), .out_p(op0), .out_ovf(ov[0]));
    bicubic_mul_pipe #(.SIGNED(1), .SHIFT(0), .OUT_W(28), .SAT(1)) d1 (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid),
        .in_ready(ir[1]), .in_a(in_a), .in_b(in_b), .out_valid(ovd[1]),
        .out_ready(out_ready), .out_p(op1), .out_ovf(ov[1]));
    bicubic_mul_pipe #(.SIGNED(0), .SHIFT(8), .OUT_W(28), .SAT(1)) d2 (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid),
        .in_ready(ir[2]), .in_a(in_a), .in_b(in_b), .out_valid(ovd[2]),
        .out_ready(out_ready), .out_p(op2), .out_ovf(ov[2]));
    bicubic_mul_pipe #(.SIGNED(1), .SHIFT(0), .OUT_W(16), .SAT(1)) d3 (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid),
        .in_ready(ir[3]), .in_a(in_a), .in_b(in_b), .out_valid(ovd[3]),
        .out_ready(out_ready), .out_p(op3), .out_ovf(ov[3]));
    bicubic_mul_pipe #(.SIGNED(1), .SHIFT(0), .OUT_W(16), .SAT(0)) d4 (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid),
        .in_ready(ir[4]), .in_a(in_a), .in_b(in_b), .out_valid(ovd[4]),
        .out_ready(out_ready), .out_p(op4), .out_ovf(ov[4]));

    task automatic chk(input string tag, input longint obs, input longint exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reference: exact integer product, floor((P + half) / 2^SH), clamp or wrap.
    function automatic longint model(input int k, input longint ar,
                                     input longint br, output bit ovf);
        longint a = ar;
        longint b = br;
        longint p, r, hi, lo;
        if (SG[k] != 0) begin
            if (a >= 512) a -= 1024;
            if (b >= 131072) b -= 262144;
        end
        p = a * b;
        r = p;
        if (SH[k] > 0)
            r = (p + (longint'(1) <<< (SH[k] - 1))) >>> SH[k];
        if (SG[k] != 0) begin
            hi = (longint'(1) <<< (OW[k] - 1)) - 1;
            lo = -(longint'(1) <<< (OW[k] - 1));
        end else begin
            hi = (longint'(1) <<< OW[k]) - 1;
            lo = 0;
        end
        ovf = (r > hi) || (r < lo);
        if (ST[k] != 0 && r > hi) r = hi;
        if (ST[k] != 0 && r < lo) r = lo;
        return r & ((longint'(1) <<< OW[k]) - 1);
    endfunction

    task automatic compare(input beat_t bt);
        longint exp, obs;
        bit     eo;
        for (int k = 0; k < NI; k++) begin
            chk($sformatf("valid_d%0d", k), longint'(ovd[k]), 1);
            for (int ln = 0; ln < 4; ln++) begin
                exp = model(k, longint'(bt.a[ln*10 +: 10]),
                            longint'(bt.b[ln*18 +: 18]), eo);
                obs = longint'(op[k] >> (ln * OW[k]))
                      & ((longint'(1) <<< OW[k]) - 1);
                chk($sformatf("p_d%0d_l%0d", k, ln), obs, exp);
                chk($sformatf("ovf_d%0d_l%0d", k, ln),
                    longint'(ov[k][ln]), longint'(eo));
            end
        end
    endtask

    task automatic tick(input bit iv, input logic [39:0] a,
                        input logic [71:0] b, input bit ordy,
                        input bit fl, output bit acc);
        beat_t bt;
        @(negedge clk);
        in_valid  = iv;
        in_a      = a;
        in_b      = b;
        out_ready = ordy;
        flush     = fl;
        #1;
        if (ordy)
            chk("in_ready_free", longint'(ir[0]), 1);
        if (q.size() == 0) begin
            chk("stale_beat", longint'(ovd[0]), 0);
        end else if (ovd[0]) begin
            compare(q[0]);
            if (ordy) begin
                void'(q.pop_front());
                n_out++;
            end
        end
        acc = iv && ir[0] && !fl;
        if (acc) begin
            bt.a = a;
            bt.b = b;
            q.push_back(bt);
        end
        if (fl)
            q.delete();
    endtask

    task automatic drain(input string tag);
        bit acc;
        for (int t = 0; t < 30 && q.size() != 0; t++)
            tick(0, '0, '0, 1, 0, acc);
        chk(tag, longint'(q.size()), 0);
    endtask

    task automatic single(input logic [9:0] a, input logic [17:0] b);
        bit acc;
        tick(1, {4{a}}, {4{b}}, 1, 0, acc);
        drain("single_drain");
    endtask

    function automatic logic [39:0] ra();
        return 40'({$urandom(), $urandom()});
    endfunction

    function automatic logic [71:0] rb();
        return 72'({$urandom(), $urandom(), $urandom()});
    endfunction

    initial begin
        bit          acc;
        int          sent;
        int          base;
        logic [39:0] va;
        logic [71:0] vb;

        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0;
        out_ready = 1'b0; in_a = '0; in_b = '0;
        #1;
        chk("rst_valid", longint'(ovd[0]), 0);
        chk("rst_in_ready", longint'(ir[0]), 1);
        chk("rst_p_zero", longint'(op[0] != 0), 0);
        chk("rst_ovf", longint'(ov[0]), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Latency: output visible after the 4th edge from accept.
        tick(1, {4{10'd1023}}, {4{18'd262143}}, 1, 0, acc);
        chk("lat_accept", longint'(acc), 1);
        for (int t = 1; t <= 3; t++) begin
            tick(0, '0, '0, 1, 0, acc);
            chk($sformatf("lat_idle_%0d", t), longint'(ovd[0]), 0);
        end
        tick(0, '0, '0, 1, 0, acc);
        chk("lat_valid", longint'(ovd[0]), 1);
        chk("u_max", longint'(op[0][27:0]), 268172289);
        chk("u_max_ovf", longint'(ov[0][0]), 0);
        drain("lat_drain");

        single(10'h200, 18'd131071);
        chk("s28_neg", longint'(op[1][27:0]), 201327104);
        chk("s28_neg_ovf", longint'(ov[1][0]), 0);
        chk("s16_sat_neg", longint'(op[3][15:0]), 32768);
        chk("s16_sat_neg_ovf", longint'(ov[3][0]), 1);
        chk("s16_wrap_neg", longint'(op[4][15:0]), 16'h0200);
        chk("s16_wrap_neg_ovf", longint'(ov[4][0]), 1);

        single(10'd511, 18'd131071);
        chk("s16_sat_pos", longint'(op[3][15:0]), 32767);
        chk("s16_sat_pos_ovf", longint'(ov[3][0]), 1);
        chk("s16_wrap_pos", longint'(op[4][15:0]), 16'hFE01);
        chk("s16_wrap_pos_ovf", longint'(ov[4][0]), 1);

        single(10'd3, 18'd85);
        chk("sh8_255", longint'(op[2][27:0]), 1);
        single(10'd1, 18'd127);
        chk("sh8_127", longint'(op[2][27:0]), 0);
        single(10'd1, 18'd128);
        chk("sh8_128", longint'(op[2][27:0]), 1);

        // Backpressure: 8 beats, out_ready low for ticks 5..7.
        sent = 0;
        base = n_out;
        for (int t = 0; t < 60 && (sent < 8 || q.size() != 0); t++) begin
            for (int ln = 0; ln < 4; ln++) begin
                va[ln*10 +: 10] = 10'(sent + 1);
                vb[ln*18 +: 18] = 18'((sent + 1) * 1000 + ln);
            end
            tick(sent < 8, va, vb, !(t >= 5 && t <= 7), 0, acc);
            if (t >= 5 && t <= 7)
                chk("bp_in_ready_low", longint'(ir[0]), 0);
            if (acc)
                sent++;
        end
        chk("bp_delivered", longint'(n_out - base), 8);

        // Random traffic with random valid and ready.
        sent = 0;
        for (int t = 0; t < 400 && sent < 60; t++) begin
            tick($urandom_range(0, 3) != 0, ra(), rb(),
                 $urandom_range(0, 3) != 0, 0, acc);
            if (acc)
                sent++;
        end
        drain("rand_drain");

        // Flush with three beats in flight; the flush-cycle beat is dropped.
        for (int i = 0; i < 3; i++)
            tick(1, ra(), rb(), 1, 0, acc);
        tick(1, ra(), rb(), 1, 1, acc);
        chk("flush_drop", longint'(acc), 0);
        tick(0, '0, '0, 1, 0, acc);
        chk("flush_valid", longint'(ovd[0]), 0);
        for (int t = 0; t < 6; t++)
            tick(0, '0, '0, 1, 0, acc);

        // Asynchronous reset mid-stream.
        for (int i = 0; i < 5; i++)
            tick(1, ra(), rb(), 1, 0, acc);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_valid", longint'(ovd[0]), 0);
        chk("arst_p_zero", longint'(op[0] != 0), 0);
        chk("arst_ovf", longint'(ov[0]), 0);
        chk("arst_in_ready", longint'(ir[0]), 1);
        q.delete();
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int t = 0; t < 6; t++)
            tick(0, '0, '0, 1, 0, acc);

        single(10'd77, 18'd12345);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule
